// File: rtl/leitor_musica.sv
`default_nettype none
// ============================================================================
// Module   : leitor_musica
// Purpose  : Playback sequencer. Walks the note/tempo music RAM from address 0,
//            holds each note for its stored number of metronome ticks, inserts
//            a silent gap between notes and stops on the end-of-song flag or
//            after the last address.
// Revision : 1.0 - initial release
// ============================================================================
module leitor_musica #(
  parameter int NUM_NOTAS  = 256,
  parameter int GAP_CYCLES = 2500,
  localparam int c_AW      = (NUM_NOTAS > 1) ? $clog2(NUM_NOTAS) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            inicia,
  input  logic            para,
  input  logic            pausa,
  input  logic            tick,
  input  logic [3:0]      mem_nota,
  input  logic [3:0]      mem_tempo,
  input  logic            mem_fim,
  output logic [c_AW-1:0] endereco,
  output logic [3:0]      nota,
  output logic            toca,
  output logic            tocando,
  output logic            fim
);

  // Gap counter must hold GAP_CYCLES-1; the +1 keeps the width >= 1 when GAP_CYCLES is 1.
  localparam int              c_GW       = $clog2(GAP_CYCLES + 1);
  localparam logic [c_GW-1:0] c_GAP_LOAD = c_GW'(GAP_CYCLES - 1);
  localparam logic [c_AW-1:0] c_LAST     = c_AW'(NUM_NOTAS - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_BUSCA      = 3'd1,
    S_CARREGA    = 3'd2,
    S_TOCA       = 3'd3,
    S_PAUSA_NOTA = 3'd4,
    S_FIM        = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [c_AW-1:0] r_endereco;
  logic [3:0]      r_nota;
  logic [3:0]      r_restantes;
  logic [c_GW-1:0] r_gap;
  logic            r_toca;
  logic            r_tocando;
  logic            r_fim;

  // Datapath strobes produced by the next-state logic.
  logic            w_addr_clr;
  logic            w_addr_inc;
  logic            w_carrega;
  logic            w_rest_dec;
  logic            w_gap_load;
  logic            w_gap_dec;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and datapath control; abort overrides everything outside IDLE.
  always_comb begin
    w_next     = r_state;
    w_addr_clr = 1'b0;
    w_addr_inc = 1'b0;
    w_carrega  = 1'b0;
    w_rest_dec = 1'b0;
    w_gap_load = 1'b0;
    w_gap_dec  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (inicia) begin
          w_addr_clr = 1'b1;
          w_next     = S_BUSCA;
        end
      end
      S_BUSCA: begin
        // RAM read latency: data for the new address is valid next cycle.
        w_next = S_CARREGA;
      end
      S_CARREGA: begin
        if (mem_fim) begin
          w_next = S_FIM;
        end else begin
          w_carrega = 1'b1;
          w_next    = S_TOCA;
        end
      end
      S_TOCA: begin
        if (!pausa && tick) begin
          if (r_restantes <= 4'd1) begin
            w_gap_load = 1'b1;
            w_next     = S_PAUSA_NOTA;
          end else begin
            w_rest_dec = 1'b1;
          end
        end
      end
      S_PAUSA_NOTA: begin
        if (!pausa) begin
          if (r_gap == '0) begin
            // The address never wraps: the last entry ends the song.
            if (r_endereco == c_LAST) begin
              w_next = S_FIM;
            end else begin
              w_addr_inc = 1'b1;
              w_next     = S_BUSCA;
            end
          end else begin
            w_gap_dec = 1'b1;
          end
        end
      end
      S_FIM: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase

    if (para && (r_state != S_IDLE)) begin
      w_next     = S_IDLE;
      w_addr_clr = 1'b0;
      w_addr_inc = 1'b0;
      w_carrega  = 1'b0;
      w_rest_dec = 1'b0;
      w_gap_load = 1'b0;
      w_gap_dec  = 1'b0;
    end
  end

  // Address, note, duration and gap counters plus registered status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_endereco  <= '0;
      r_nota      <= 4'd0;
      r_restantes <= 4'd0;
      r_gap       <= '0;
      r_toca      <= 1'b0;
      r_tocando   <= 1'b0;
      r_fim       <= 1'b0;
    end else begin
      if (w_addr_clr) begin
        r_endereco <= '0;
      end else if (w_addr_inc) begin
        r_endereco <= r_endereco + c_AW'(1);
      end

      if (w_carrega) begin
        r_nota      <= mem_nota;
        // A zero duration still plays for one tick.
        r_restantes <= (mem_tempo == 4'd0) ? 4'd1 : mem_tempo;
      end else if (w_rest_dec) begin
        r_restantes <= r_restantes - 4'd1;
      end

      if (w_gap_load) begin
        r_gap <= c_GAP_LOAD;
      end else if (w_gap_dec) begin
        r_gap <= r_gap - c_GW'(1);
      end

      // Outputs are registered from the next state so they line up with it.
      r_toca    <= (w_next == S_TOCA);
      r_tocando <= (w_next != S_IDLE);
      r_fim     <= (w_next == S_FIM);
    end
  end

  assign endereco = r_endereco;
  assign nota     = r_nota;
  assign toca     = r_toca;
  assign tocando  = r_tocando;
  assign fim      = r_fim;

endmodule
`default_nettype wire

// File: tb/tb_leitor_musica.sv
`default_nettype none
// ============================================================================
// Module   : tb_leitor_musica
// Purpose  : Self-checking bench for leitor_musica: directed vector table,
//            hand-written corner sequences and randomized songs compared
//            against a timeline model of playback.
// Revision : 1.0 - initial release
// ============================================================================
module tb_leitor_musica;

  localparam int N   = 4;
  localparam int G   = 4;
  localparam int WIN = 300;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       inicia = 1'b0;
  logic       para = 1'b0;
  logic       pausa = 1'b0;
  logic       tick = 1'b0;
  logic [3:0] mem_nota;
  logic [3:0] mem_tempo;
  logic       mem_fim;
  logic [1:0] endereco;
  logic [3:0] nota;
  logic       toca;
  logic       tocando;
  logic       fim;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] ram_nota  [N];
  logic [3:0] ram_tempo [N];
  logic       ram_fim   [N];

  leitor_musica #(.NUM_NOTAS(N), .GAP_CYCLES(G)) dut (
    .clock    (clock),
    .reset    (reset),
    .inicia   (inicia),
    .para     (para),
    .pausa    (pausa),
    .tick     (tick),
    .mem_nota (mem_nota),
    .mem_tempo(mem_tempo),
    .mem_fim  (mem_fim),
    .endereco (endereco),
    .nota     (nota),
    .toca     (toca),
    .tocando  (tocando),
    .fim      (fim)
  );

  always #5 clock = ~clock;

  // Synchronous-read music RAM: one cycle of latency after the address.
  always @(posedge clock) begin
    mem_nota  <= ram_nota[endereco];
    mem_tempo <= ram_tempo[endereco];
    mem_fim   <= ram_fim[endereco];
  end

  task automatic check(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h at t=%0t", nm, got, exp, $time);
    end
  endtask

  // Output bundle {toca, tocando, fim, endereco[1:0], nota[3:0]}.
  function automatic logic [8:0] outs();
    return {toca, tocando, fim, endereco, nota};
  endfunction

  // Drive one cycle of inputs and move to just after the next active edge.
  task automatic step(input logic rs, input logic ini, input logic pa,
                      input logic pz, input logic tk);
    reset = rs; inicia = ini; para = pa; pausa = pz; tick = tk;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic song(input logic [3:0] n0, input logic [3:0] t0, input logic f0,
                      input logic [3:0] n1, input logic [3:0] t1, input logic f1,
                      input logic [3:0] n2, input logic [3:0] t2, input logic f2);
    ram_nota[0] = n0; ram_tempo[0] = t0; ram_fim[0] = f0;
    ram_nota[1] = n1; ram_tempo[1] = t1; ram_fim[1] = f1;
    ram_nota[2] = n2; ram_tempo[2] = t2; ram_fim[2] = f2;
    ram_nota[3] = 4'd9; ram_tempo[3] = 4'd1; ram_fim[3] = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [4:0] in;   // {reset, inicia, para, pausa, tick}
    logic       chk;
    logic [8:0] ex;   // outputs expected during this cycle
  } vec_t;

  vec_t tv [23];

  // ---------------- timeline model for random runs ----------------
  bit         tk_a  [WIN];
  bit         pz_a  [WIN];
  bit         ini_a [WIN];
  logic [8:0] ex_a  [WIN];
  bit         e_toca[WIN];
  bit         e_tcd [WIN];
  bit         e_fim [WIN];
  logic [1:0] e_end [WIN];
  logic [3:0] e_nota[WIN];

  // Plays the song cycle-range by cycle-range: each note occupies the span from
  // its first TOCA cycle to its dur-th counted tick, then G unpaused gap cycles.
  task automatic build(input int i0, output bit ok);
    int t, addr, s, k, e, f, cnt, dur;
    bit done;
    for (int c = 0; c < WIN; c++) begin
      e_toca[c] = 0; e_tcd[c] = 0; e_fim[c] = 0; e_end[c] = 2'd0; e_nota[c] = 4'd0;
    end
    ok = 1; done = 0; t = i0; addr = 0;
    while (!done && ok) begin
      for (int c = t + 1; c < WIN; c++) begin
        e_end[c] = 2'(addr); e_tcd[c] = 1;
      end
      if (ram_fim[addr]) begin
        f = t + 3; done = 1;
      end else begin
        s = t + 3;
        for (int c = s; c < WIN; c++) e_nota[c] = ram_nota[addr];
        dur = (ram_tempo[addr] == 0) ? 1 : int'(ram_tempo[addr]);
        k = s - 1; cnt = 0;
        while (cnt < dur && k < WIN - 8) begin
          k++;
          if (tk_a[k] && !pz_a[k]) cnt++;
        end
        if (cnt < dur) ok = 0;
        for (int c = s; c <= k; c++) e_toca[c] = 1;
        e = k; cnt = 0;
        while (cnt < G && e < WIN - 8) begin
          e++;
          if (!pz_a[e]) cnt++;
        end
        if (cnt < G) ok = 0;
        if (addr == N - 1) begin
          f = e + 1; done = 1;
        end else begin
          addr++; t = e;
        end
      end
      if (done) begin
        if (f >= WIN - 1) ok = 0;
        else begin
          e_fim[f] = 1;
          for (int c = f + 1; c < WIN; c++) e_tcd[c] = 0;
        end
      end
    end
    for (int c = 0; c < WIN; c++)
      ex_a[c] = {e_toca[c], e_tcd[c], e_fim[c], e_end[c], e_nota[c]};
  endtask

  initial begin
    int  burst;
    int  i0;
    bit  ok;

    // Song: (3,2) (7,1) end. Ticks outside TOCA and on entry are dropped,
    // pausa freezes a tick and stretches the gap, inicia mid-song is ignored.
    tv[0]  = '{5'b10000, 1'b0, 9'b0_0_0_00_0000};
    tv[1]  = '{5'b01001, 1'b1, 9'b0_0_0_00_0000};
    tv[2]  = '{5'b00001, 1'b1, 9'b0_1_0_00_0000};
    tv[3]  = '{5'b00001, 1'b1, 9'b0_1_0_00_0000};
    tv[4]  = '{5'b00001, 1'b1, 9'b1_1_0_00_0011};
    tv[5]  = '{5'b00011, 1'b1, 9'b1_1_0_00_0011};
    tv[6]  = '{5'b00001, 1'b1, 9'b1_1_0_00_0011};
    tv[7]  = '{5'b00010, 1'b1, 9'b0_1_0_00_0011};
    for (int i = 8; i <= 10; i++) tv[i] = '{5'b00000, 1'b1, 9'b0_1_0_00_0011};
    tv[11] = '{5'b01000, 1'b1, 9'b0_1_0_00_0011};
    tv[12] = '{5'b00000, 1'b1, 9'b0_1_0_01_0011};
    tv[13] = '{5'b00001, 1'b1, 9'b0_1_0_01_0011};
    tv[14] = '{5'b00001, 1'b1, 9'b1_1_0_01_0111};
    for (int i = 15; i <= 18; i++) tv[i] = '{5'b00000, 1'b1, 9'b0_1_0_01_0111};
    tv[19] = '{5'b00000, 1'b1, 9'b0_1_0_10_0111};
    tv[20] = '{5'b00000, 1'b1, 9'b0_1_0_10_0111};
    tv[21] = '{5'b00000, 1'b1, 9'b0_1_1_10_0111};
    tv[22] = '{5'b00000, 1'b1, 9'b0_0_0_10_0111};

    song(4'd3, 4'd2, 1'b0, 4'd7, 4'd1, 1'b0, 4'd0, 4'd0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 23; i++) begin
      if (tv[i].chk) check($sformatf("table_row%0d", i), int'(outs()), int'(tv[i].ex));
      step(tv[i].in[4], tv[i].in[3], tv[i].in[2], tv[i].in[1], tv[i].in[0]);
    end

    // End flag at address 0: fim at cycle 3, toca never asserted.
    song(4'd4, 4'd2, 1'b1, 4'd0, 4'd1, 1'b0, 4'd0, 4'd1, 1'b0);
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      check($sformatf("fim0_toca_c%0d", c), int'(toca), 0);
      check($sformatf("fim0_fim_c%0d", c), int'(fim), int'(c == 3));
      check($sformatf("fim0_tocando_c%0d", c), int'(tocando), int'(c >= 1 && c <= 3));
      step(1'b0, c == 0, 1'b0, 1'b0, 1'b0);
    end

    // Zero tempo plays until the first counted tick.
    song(4'd5, 4'd0, 1'b0, 4'd0, 4'd0, 1'b1, 4'd0, 4'd0, 1'b1);
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      check($sformatf("zero_toca_c%0d", c), int'(toca), int'(c >= 3 && c <= 6));
      if (c == 3) check("zero_nota", int'(nota), 5);
      step(1'b0, c == 0, 1'b0, 1'b0, (c == 1) || (c == 2) || (c == 6));
    end

    // Abort during the second note, then restart from address 0.
    song(4'd3, 4'd1, 1'b0, 4'd7, 4'd2, 1'b0, 4'd0, 4'd0, 1'b1);
    do_reset();
    for (int c = 0; c <= 16; c++) begin
      if (c == 11) check("para_before", int'(outs()), int'(9'b1_1_0_01_0111));
      if (c >= 12 && c <= 14) check($sformatf("para_after_c%0d", c), int'(outs()), int'(9'b0_0_0_01_0111));
      if (c == 16) check("para_restart", int'({tocando, endereco}), int'(3'b1_00));
      step(1'b0, (c == 0) || (c == 15), c == 11, 1'b0, c == 3);
    end

    // Synchronous reset while a note plays.
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      if (c == 4) check("rst_in_toca_before", int'(outs()), int'(9'b1_1_0_00_0011));
      if (c == 5) check("rst_in_toca_after", int'(outs()), 0);
      step(c == 4, c == 0, 1'b0, 1'b0, 1'b0);
    end

    // Randomized songs; the first has no end flag so all four addresses play.
    for (int run = 0; run < 4; run++) begin
      for (int a = 0; a < N; a++) begin
        ram_nota[a]  = 4'($urandom_range(0, 15));
        ram_tempo[a] = 4'($urandom_range(0, 4));
        ram_fim[a]   = (run != 0) && ($urandom_range(0, 3) == 0);
      end
      burst = 0;
      for (int c = 0; c < WIN; c++) begin
        tk_a[c] = (c % 5 == 0) || ($urandom_range(0, 2) == 0);
        if (burst > 0) begin
          pz_a[c] = 1; burst--;
        end else begin
          pz_a[c] = 0;
          if ($urandom_range(0, 14) == 0) burst = $urandom_range(1, 8);
        end
      end
      i0 = $urandom_range(1, 3);
      build(i0, ok);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL rand_model_window run=%0d song did not finish within %0d cycles", run, WIN);
      end
      for (int c = 0; c < WIN; c++)
        ini_a[c] = (c == i0) || (e_tcd[c] && ($urandom_range(0, 5) == 0));
      do_reset();
      for (int c = 0; c < WIN; c++) begin
        check($sformatf("rand_r%0d_c%0d", run, c), int'(outs()), int'(ex_a[c]));
        step(1'b0, ini_a[c], 1'b0, pz_a[c], tk_a[c]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/leitor_musica.md
# leitor_musica

Playback sequencer that reads a recorded song back out of the note/tempo music RAM and replays it. It complements the recording path that writes (nota, tempo) pairs. It walks addresses from 0 and fetches each entry. It holds the note on the buzzer selector for the stored number of metronome ticks, inserts a short silent gap, and stops at the end-of-song flag or at the last address. It sits in the datapath between the metronome, the music RAM read port, and the buzzer/LED note mux.

## Interface
- NUM_NOTAS, 256: RAM depth; address width is $clog2(NUM_NOTAS).
- GAP_CYCLES, 2500: clock cycles of silence between consecutive notes; legal range ≥1.
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high; returns the block to IDLE.
- inicia  in  1  single-cycle pulse; starts playback from address 0. Only honoured in IDLE.
- para  in  1  abort; level-sensitive; honoured in every state except IDLE.
- pausa  in  1  level; freezes tick and gap counting; outputs hold.
- tick  in  1  single-cycle pulse, one per metronome subdivision.
- mem_nota  in  4  RAM note output; valid 1 cycle after `endereco` changes.
- mem_tempo  in  4  RAM duration output, in ticks; same latency as `mem_nota`.
- mem_fim  in  1  end-of-song flag for the current address; same latency as `mem_nota`.
- endereco  out  $clog2(NUM_NOTAS)  RAM read address.
- nota  out  4  note code for the buzzer/LED mux.
- toca  out  1  buzzer enable.
- tocando  out  1  high in every state except IDLE.
- fim  out  1  single-cycle pulse when playback completes normally.

## Operation
- States: IDLE, BUSCA, CARREGA, TOCA, PAUSA_NOTA, FIM.
- IDLE:
  - Outputs: toca=0, tocando=0.
  - On `inicia`: endereco←0, go to BUSCA.
- BUSCA: one wait cycle for RAM read latency, then go to CARREGA.
- CARREGA:
  - If mem_fim=1: go to FIM. The stored nota/tempo are ignored.
  - Otherwise: nota←mem_nota, restantes←(mem_tempo==0 ? 1 : mem_tempo), go to TOCA.
- TOCA:
  - Output: toca=1.
  - Each `tick` with pausa=0 decrements `restantes`.
  - A tick arriving when restantes==1 moves to PAUSA_NOTA and loads gap counter←GAP_CYCLES-1.
- PAUSA_NOTA:
  - Output: toca=0. `nota` holds its value.
  - The gap counter decrements every cycle while pausa=0.
  - At 0: if endereco==NUM_NOTAS-1, go to FIM; otherwise endereco←endereco+1 and go to BUSCA.
- FIM: fim=1 for exactly this cycle; the next state is IDLE.
- `para` in any non-IDLE state: next state is IDLE, toca←0, fim is not pulsed, endereco holds its value.
- `pausa` does not stall BUSCA or CARREGA. It takes effect starting in TOCA.
- Ticks arriving outside TOCA are dropped and not queued. A tick in the same cycle as the entry into TOCA is not counted; counting starts on the first cycle spent in TOCA.
- `restantes` is 4 bits wide, so the maximum duration is 15 ticks.
- The address never wraps. The last address is played, then the block goes to FIM.
- Priority, highest first: reset > para > pausa > tick/gap counting. `inicia` outside IDLE is ignored.

## Timing
- Reset values: endereco=0, nota=0, toca=0, tocando=0, fim=0. Internal counters reset to 0.
- All outputs are registered.
- `inicia` at cycle 0:
  - BUSCA at cycle 1 with endereco=0.
  - CARREGA at cycle 2.
  - TOCA at cycle 3: toca=1 and the new nota are visible.
- Note-to-note: the last tick at cycle t puts PAUSA_NOTA at t+1. TOCA for the next note begins at t+GAP_CYCLES+3, which covers the gap plus BUSCA and CARREGA.
- The end flag at address k gives fim=1 exactly 2 cycles after endereco becomes k. IDLE follows one cycle later.
- `para` at cycle c gives IDLE and toca=0 at c+1.

## Test plan
- Song {(nota 3, tempo 2), (nota 7, tempo 1), fim}, tick every 10 cycles, GAP_CYCLES=4:
  - Expected: toca high for 2 ticks with nota=3, then 4 low cycles, then 1 tick with nota=7.
  - Then fim pulses once, with endereco=2 at that point.
  - tocando falls one cycle after fim.
- mem_fim=1 at address 0: `inicia` → fim at cycle 3, toca never asserted.
- Zero tempo (nota 5, tempo 0):
  - Expected: treated as 1 tick, so toca lasts exactly until the first counted tick.
- `para` during TOCA of the second note:
  - Expected: toca=0 and tocando=0 next cycle, no fim, endereco stays 1.
  - A subsequent `inicia` restarts at endereco 0.
- `pausa` held for 3 ticks mid-note (tempo 3):
  - Expected: note length is 3 counted ticks plus the paused span.
  - `pausa` during the gap stretches the gap by the number of paused cycles.
- NUM_NOTAS=4, no fim flag in the RAM:
  - Expected: addresses 0..3 played in order, then fim.
  - endereco never returns to 0 during playback.
  - `inicia` asserted while tocando=1 is ignored.
- Synchronous reset asserted in TOCA: all outputs return to their reset values next cycle.
